// File: rtl/lut_qsq_multiplier_module.sv
// Quarter-square multiplier: A*B = ((A+B)^2 - (A-B)^2)/4 using one single-port square ROM.
// Optional debug outputs I1_Sig/I2_Sig/Q1_Sig/Q2_Sig are enabled by defining LUT_MULT_DEBUG_EN.
module lut_qsq_multiplier_module #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_sig,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 done_sig,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy_sig
`ifdef LUT_MULT_DEBUG_EN
    ,
    output logic [WIDTH+1:0]     I1_Sig,
    output logic [WIDTH+1:0]     I2_Sig,
    output logic [2*WIDTH+1:0]   Q1_Sig,
    output logic [2*WIDTH+1:0]   Q2_Sig
`endif
);

    localparam int SW    = WIDTH + 2;
    localparam int AW    = WIDTH + 1;
    localparam int QW    = 2 * WIDTH + 2;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [2:0] {IDLE, SUM, RD1, RD2, CALC, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic                   mode_q;
    logic signed [SW-1:0]   a_ext;
    logic signed [SW-1:0]   b_ext;
    logic signed [SW-1:0]   i1;
    logic signed [SW-1:0]   i2;
    logic signed [SW-1:0]   rom_sel;
    logic [AW-1:0]          rom_addr;
    logic [QW-1:0]          q1;
    logic [QW-1:0]          q2;
    logic [QW-1:0]          diff;
    logic [QW-1:0]          rom_table [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom_table[k] = QW'(k * k);
    end

    // The difference is taken modulo 2^QW; dropping the two LSBs yields the same low
    // 2*WIDTH bits as an arithmetic shift of the full-precision signed difference.
    always_comb begin
        a_ext    = mode_q ? {{2{a_q[WIDTH-1]}}, a_q} : {2'b00, a_q};
        b_ext    = mode_q ? {{2{b_q[WIDTH-1]}}, b_q} : {2'b00, b_q};
        rom_sel  = (state == RD2) ? i2 : i1;
        rom_addr = rom_sel[SW-1] ? AW'(-rom_sel) : rom_sel[AW-1:0];
        diff     = q1 - q2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            done_sig <= 1'b0;
            busy_sig <= 1'b0;
            product  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            i1       <= '0;
            i2       <= '0;
            q1       <= '0;
            q2       <= '0;
        end else begin
            done_sig <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_sig) begin
                        a_q      <= A;
                        b_q      <= B;
                        mode_q   <= signed_mode;
                        busy_sig <= 1'b1;
                        state    <= SUM;
                    end
                end
                SUM: begin
                    i1    <= a_ext + b_ext;
                    i2    <= a_ext - b_ext;
                    state <= RD1;
                end
                RD1: begin
                    q1    <= rom_table[rom_addr];
                    state <= RD2;
                end
                RD2: begin
                    q2    <= rom_table[rom_addr];
                    state <= CALC;
                end
                CALC: begin
                    product <= diff[QW-1:2];
                    state   <= DONE;
                end
                DONE: begin
                    done_sig <= 1'b1;
                    busy_sig <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LUT_MULT_DEBUG_EN
    assign I1_Sig = i1;
    assign I2_Sig = i2;
    assign Q1_Sig = q1;
    assign Q2_Sig = q2;
`endif

endmodule

// File: tb/tb_lut_qsq_multiplier_module.sv
// Directed bench for lut_qsq_multiplier_module at WIDTH=8 and WIDTH=4.
// Debug-port checks are compiled in when LUT_MULT_DEBUG_EN is defined.
module tb_lut_qsq_multiplier_module;

    logic        clk;
    logic        rst_n;
    logic        start_sig;
    logic        signed_mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        done_sig;
    logic [15:0] product;
    logic        busy_sig;

    logic        start4;
    logic        mode4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        done4;
    logic [7:0]  prod4;
    logic        busy4;

    int n_checks;
    int n_fail;

`ifdef LUT_MULT_DEBUG_EN
    logic [9:0]  i1_sig;
    logic [9:0]  i2_sig;
    logic [17:0] q1_sig;
    logic [17:0] q2_sig;
    logic [5:0]  i1_sig4;
    logic [5:0]  i2_sig4;
    logic [9:0]  q1_sig4;
    logic [9:0]  q2_sig4;
`endif

    lut_qsq_multiplier_module #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_sig   (start_sig),
        .signed_mode (signed_mode),
        .A           (a),
        .B           (b),
        .done_sig    (done_sig),
        .product     (product),
        .busy_sig    (busy_sig)
`ifdef LUT_MULT_DEBUG_EN
        ,
        .I1_Sig      (i1_sig),
        .I2_Sig      (i2_sig),
        .Q1_Sig      (q1_sig),
        .Q2_Sig      (q2_sig)
`endif
    );

    lut_qsq_multiplier_module #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_sig   (start4),
        .signed_mode (mode4),
        .A           (a4),
        .B           (b4),
        .done_sig    (done4),
        .product     (prod4),
        .busy_sig    (busy4)
`ifdef LUT_MULT_DEBUG_EN
        ,
        .I1_Sig      (i1_sig4),
        .I2_Sig      (i2_sig4),
        .Q1_Sig      (q1_sig4),
        .Q2_Sig      (q2_sig4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one request on the WIDTH=8 instance and counts negedges until done_sig.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                          output int cycles, output bit seen);
        @(negedge clk);
        a = av; b = bv; signed_mode = sm; start_sig = 1'b1;
        cycles = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) start_sig = 1'b0;
            if (done_sig) begin seen = 1'b1; cycles = i; end
        end
    endtask

    task automatic run_op4(input logic [3:0] av, input logic [3:0] bv, input logic sm,
                           output int cycles, output bit seen);
        @(negedge clk);
        a4 = av; b4 = bv; mode4 = sm; start4 = 1'b1;
        cycles = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) start4 = 1'b0;
            if (done4) begin seen = 1'b1; cycles = i; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_sig !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done actual=%b required=0", done_sig); end
        n_checks++;
        if (busy_sig !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy actual=%b required=0", busy_sig); end
        n_checks++;
        if (product !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_product actual=%h required=0000", product); end
        n_checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0 || prod4 !== 8'h00) begin
            n_fail++; $display("[TB] FAIL reset_w4 actual done=%b busy=%b prod=%h required 0/0/00", done4, busy4, prod4);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int  cyc;
        bit  seen;
        @(negedge clk);
        a = 8'd15; b = 8'd34; signed_mode = 1'b1; start_sig = 1'b1;
        @(negedge clk);
        start_sig = 1'b0;
        n_checks++;
        if (busy_sig !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy actual=%b required=1", busy_sig); end
        seen = 1'b0; cyc = 1;
        for (int i = 2; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (done_sig) begin seen = 1'b1; cyc = i; end
        end
        n_checks++;
        if (!seen || cyc != 6) begin n_fail++; $display("[TB] FAIL basic_latency actual=%0d seen=%b required=6", cyc, seen); end
        n_checks++;
        if (product !== 16'h01FE) begin n_fail++; $display("[TB] FAIL basic_product actual=%h required=01fe", product); end
        n_checks++;
        if (busy_sig !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_at_done actual=%b required=0", busy_sig); end
`ifdef LUT_MULT_DEBUG_EN
        n_checks++;
        if (i1_sig !== 10'h031 || i2_sig !== 10'h3ED || q1_sig !== 18'd2401 || q2_sig !== 18'd361) begin
            n_fail++;
            $display("[TB] FAIL debug_ports actual=%h/%h/%0d/%0d required=031/3ed/2401/361", i1_sig, i2_sig, q1_sig, q2_sig);
        end
`endif
        @(negedge clk);
        n_checks++;
        if (done_sig !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_pulse_width actual=%b required=0", done_sig); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        int pulses;
        @(negedge clk);
        a = 8'hEC; b = 8'd59; signed_mode = 1'b1; start_sig = 1'b1;
        seen = 1'b0; cyc = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (done_sig) begin seen = 1'b1; cyc = i; end
        end
        n_checks++;
        if (!seen || cyc != 6) begin n_fail++; $display("[TB] FAIL b2b_latency1 actual=%0d seen=%b required=6", cyc, seen); end
        n_checks++;
        if (product !== 16'hFB64) begin n_fail++; $display("[TB] FAIL b2b_product1 actual=%h required=fb64", product); end
        a = 8'h81; b = 8'd127;
        seen = 1'b0; cyc = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (done_sig) begin seen = 1'b1; cyc = i; end
        end
        start_sig = 1'b0;
        n_checks++;
        if (!seen || cyc != 6) begin n_fail++; $display("[TB] FAIL b2b_latency2 actual=%0d seen=%b required=6", cyc, seen); end
        n_checks++;
        if (product !== 16'hC0FF) begin n_fail++; $display("[TB] FAIL b2b_product2 actual=%h required=c0ff", product); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_sig) pulses++;
        end
        n_checks++;
        if (pulses != 0 || busy_sig !== 1'b0) begin
            n_fail++; $display("[TB] FAIL b2b_extra_done actual pulses=%0d busy=%b required 0/0", pulses, busy_sig);
        end
    endtask

    task automatic test_boundaries();
        int cyc;
        bit seen;
        run_op(8'h80, 8'h80, 1'b1, cyc, seen);
        n_checks++;
        if (!seen || product !== 16'h4000) begin n_fail++; $display("[TB] FAIL signed_min_sq actual=%h seen=%b required=4000", product, seen); end
        run_op(8'hFF, 8'hFF, 1'b0, cyc, seen);
        n_checks++;
        if (!seen || product !== 16'hFE01) begin n_fail++; $display("[TB] FAIL unsigned_max_sq actual=%h seen=%b required=fe01", product, seen); end
        run_op(8'd0, 8'd77, 1'b0, cyc, seen);
        n_checks++;
        if (!seen || product !== 16'h0000) begin n_fail++; $display("[TB] FAIL zero_operand actual=%h seen=%b required=0000", product, seen); end
    endtask

    task automatic test_operand_hold();
        int cyc;
        bit seen;
        @(negedge clk);
        a = 8'd3; b = 8'd7; signed_mode = 1'b0; start_sig = 1'b1;
        @(negedge clk);
        start_sig = 1'b0; a = 8'd100; b = 8'd50;
        @(negedge clk);
        a = 8'd9; b = 8'd9; signed_mode = 1'b1;
        seen = 1'b0; cyc = 2;
        for (int i = 3; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (done_sig) begin seen = 1'b1; cyc = i; end
        end
        n_checks++;
        if (!seen || product !== 16'd21) begin n_fail++; $display("[TB] FAIL operand_hold actual=%0d seen=%b required=21", product, seen); end
    endtask

    task automatic test_reset_abort();
        int cyc;
        bit seen;
        int pulses;
        @(negedge clk);
        a = 8'd15; b = 8'd34; signed_mode = 1'b1; start_sig = 1'b1;
        @(negedge clk);
        start_sig = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (product !== 16'h0000 || busy_sig !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_clear actual prod=%h busy=%b required 0000/0", product, busy_sig);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_sig) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("[TB] FAIL abort_no_done actual=%0d required=0", pulses); end
        run_op(8'd15, 8'd34, 1'b1, cyc, seen);
        n_checks++;
        if (!seen || cyc != 6 || product !== 16'h01FE) begin
            n_fail++; $display("[TB] FAIL after_abort actual=%h cyc=%0d required=01fe cyc 6", product, cyc);
        end
    endtask

    task automatic test_width4();
        int cyc;
        bit seen;
        run_op4(4'h8, 4'h8, 1'b1, cyc, seen);
        n_checks++;
        if (!seen || cyc != 6 || prod4 !== 8'h40) begin n_fail++; $display("[TB] FAIL w4_min_sq actual=%h cyc=%0d required=40 cyc 6", prod4, cyc); end
        run_op4(4'h8, 4'h7, 1'b1, cyc, seen);
        n_checks++;
        if (!seen || prod4 !== 8'hC8) begin n_fail++; $display("[TB] FAIL w4_min_max actual=%h seen=%b required=c8", prod4, seen); end
        run_op4(4'h0, 4'h5, 1'b1, cyc, seen);
        n_checks++;
        if (!seen || prod4 !== 8'h00) begin n_fail++; $display("[TB] FAIL w4_zero actual=%h seen=%b required=00", prod4, seen); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; start_sig = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundaries();
        test_operand_hold();
        test_reset_abort();
        test_width4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
